// File: rtl/enoc_switch_allocator.sv
// ---------------------------------------------------------------------------
// enoc_switch_allocator
//
// Output-port allocator for an ENoC router. Each input presents a one-hot
// (or zero) output request from its route calculator; every output picks
// one requesting input using a per-output round-robin pointer. Grants are
// combinational in the same cycle; pointer (and lock) state is registered.
//
// Optional feature macro: ENOC_PKT_LOCK_EN
//   When defined, an output that grants a non-tail flit locks onto that
//   input (wormhole) until the owner's tail flit is granted. When undefined,
//   every grant advances the pointer and i_tail is ignored.
//
// Ports
//   clk             clock
//   reset           synchronous active-high reset; forces all outputs to 0
//   i_output_req    N*M  request matrix, input i at [i*M +: M], output 0 at
//                        the MSB of each slice
//   i_tail          N    head flit of input i is a tail / single-flit packet
//   i_en            M    output m can accept a flit this cycle
//   o_output_grant  N*M  grant matrix, same layout as i_output_req
//   o_input_grant   N    dequeue strobe per input (OR of its grant row)
//   o_output_val    M    output m carries a granted flit
//   o_output_sel    M*W  crossbar select, output m at [m*W +: W]; 0 if idle
// ---------------------------------------------------------------------------
module enoc_switch_allocator #(
  parameter int N = 5,
  parameter int M = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*M-1:0]   i_output_req,
  input  logic [N-1:0]     i_tail,
  input  logic [M-1:0]     i_en,
  output logic [N*M-1:0]   o_output_grant,
  output logic [N-1:0]     o_input_grant,
  output logic [M-1:0]     o_output_val,
  output logic [M*W-1:0]   o_output_sel
);

  // Requests regrouped by output column so each arbiter sees its N bits.
  logic [M-1:0][N-1:0] req_col;
  logic [M-1:0][W-1:0] ptr;
  logic [M-1:0]        win_val;
  logic [M-1:0][W-1:0] win_idx;

`ifdef ENOC_PKT_LOCK_EN
  logic [M-1:0]        lock;
  logic [M-1:0][W-1:0] owner;
`else
  logic unused_tail;
  assign unused_tail = ^i_tail;
`endif

  // Advance an input index by one, wrapping N-1 back to 0 (N need not be a
  // power of two, so plain overflow is not enough).
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return (v == W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // Output 0 sits at the MSB of each input's request slice.
  always_comb begin
    req_col = '0;
    for (int m = 0; m < M; m++) begin
      for (int i = 0; i < N; i++) begin
        req_col[m][i] = i_output_req[i*M + (M-1-m)];
      end
    end
  end

  // Per-output arbitration. A locked output only listens to its owner;
  // otherwise inputs are scanned from ptr upward with wrap-around and the
  // first requester wins.
  always_comb begin
    int idx;
    win_val = '0;
    win_idx = '0;
    idx     = 0;
    for (int m = 0; m < M; m++) begin
      if (i_en[m]) begin
`ifdef ENOC_PKT_LOCK_EN
        if (lock[m]) begin
          if (req_col[m][owner[m]]) begin
            win_val[m] = 1'b1;
            win_idx[m] = owner[m];
          end
        end else
`endif
        begin
          for (int k = 0; k < N; k++) begin
            idx = int'(ptr[m]) + k;
            if (idx >= N) idx = idx - N;
            if (!win_val[m] && req_col[m][idx]) begin
              win_val[m] = 1'b1;
              win_idx[m] = W'(idx);
            end
          end
        end
      end
    end
  end

  // Drive grant matrix, dequeue strobes and crossbar selects from the
  // per-output winners. Reset blanks everything regardless of requests.
  always_comb begin
    o_output_grant = '0;
    o_input_grant  = '0;
    o_output_val   = '0;
    o_output_sel   = '0;
    if (!reset) begin
      for (int m = 0; m < M; m++) begin
        if (win_val[m]) begin
          o_output_val[m]                                 = 1'b1;
          o_output_sel[m*W +: W]                          = win_idx[m];
          o_output_grant[int'(win_idx[m])*M + (M-1-m)]    = 1'b1;
          o_input_grant[win_idx[m]]                       = 1'b1;
        end
      end
    end
  end

  // State update. Outputs with no grant (idle, no credit or owner bubble)
  // keep their pointer and lock untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
`ifdef ENOC_PKT_LOCK_EN
      lock  <= '0;
      owner <= '0;
`endif
    end else begin
      for (int m = 0; m < M; m++) begin
        if (win_val[m]) begin
`ifdef ENOC_PKT_LOCK_EN
          if (lock[m]) begin
            if (i_tail[owner[m]]) begin
              lock[m] <= 1'b0;
              ptr[m]  <= wrap_inc(owner[m]);
            end
          end else if (i_tail[win_idx[m]]) begin
            ptr[m] <= wrap_inc(win_idx[m]);
          end else begin
            lock[m]  <= 1'b1;
            owner[m] <= win_idx[m];
          end
`else
          ptr[m] <= wrap_inc(win_idx[m]);
`endif
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Each input's request vector must be one-hot or zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    a_req_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0(i_output_req[gi*M +: M]));
  end
`endif

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_enoc_switch_allocator
//
// Directed bench for enoc_switch_allocator (N=5, M=5). Each scenario task
// drives a short sequence of request vectors and compares the complete
// output bundle against hand-derived grants. Lock scenarios are compiled
// when ENOC_PKT_LOCK_EN is defined, the per-flit round-robin scenario
// otherwise.
// ---------------------------------------------------------------------------
module tb_enoc_switch_allocator;

  localparam int N  = 5;
  localparam int M  = 5;
  localparam int W  = 3;
  localparam int OW = N*M + M + M*W + N;

  logic           clk;
  logic           reset;
  logic [N*M-1:0] i_output_req;
  logic [N-1:0]   i_tail;
  logic [M-1:0]   i_en;
  logic [N*M-1:0] o_output_grant;
  logic [N-1:0]   o_input_grant;
  logic [M-1:0]   o_output_val;
  logic [M*W-1:0] o_output_sel;
  logic [OW-1:0]  obs;

  int tests_run;
  int tests_failed;

  enoc_switch_allocator #(.N(N), .M(M)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_output_req   (i_output_req),
    .i_tail         (i_tail),
    .i_en           (i_en),
    .o_output_grant (o_output_grant),
    .o_input_grant  (o_input_grant),
    .o_output_val   (o_output_val),
    .o_output_sel   (o_output_sel)
  );

  assign obs = {o_output_grant, o_output_val, o_output_sel, o_input_grant};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request bit for input i asking for output m (output 0 is slice MSB).
  function automatic logic [N*M-1:0] rq(input int i, input int m);
    logic [N*M-1:0] v;
    v = '0;
    v[i*M + (M-1-m)] = 1'b1;
    return v;
  endfunction

  // Expected output bundle when output m grants input idx and nothing else.
  function automatic logic [OW-1:0] eg(input int m, input int idx);
    logic [N*M-1:0] g;
    logic [M-1:0]   v;
    logic [M*W-1:0] s;
    logic [N-1:0]   ig;
    logic [W-1:0]   iw;
    g = '0; v = '0; s = '0; ig = '0;
    iw = W'(idx);
    g[idx*M + (M-1-m)] = 1'b1;
    v[m] = 1'b1;
    s[m*W +: W] = iw;
    ig[idx] = 1'b1;
    return {g, v, s, ig};
  endfunction

  // Present one cycle of stimulus away from the rising edge.
  task automatic applyStimulus(input logic [N*M-1:0] r, input logic [N-1:0] t,
                               input logic [M-1:0] e);
    @(negedge clk);
    i_output_req = r;
    i_tail       = t;
    i_en         = e;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_output_req = '0;
    i_tail = '1;
    i_en = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [N*M-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = r | rq(i, (i + 1) % M);
    @(negedge clk);
    reset = 1'b1;
    i_output_req = r;
    i_tail = '1;
    i_en = '1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    i_output_req = '0;
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    logic [N*M-1:0] r;
    do_reset();
    r = '0;
    for (int i = 0; i < N; i++) r = r | rq(i, 2);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(r, '1, '1);
      tests_run++;
      if (obs !== eg(2, seq[c])) begin
        tests_failed++;
        $display("[TB] FAIL rr_out2 cycle %0d: got %h expected %h", c, obs, eg(2, seq[c]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*M-1:0] r;
    do_reset();
    r = '0;
    for (int i = 0; i < N; i++) r = r | rq(i, 2);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(r, '1, '1);
      tests_run++;
      if (obs !== eg(2, c)) begin
        tests_failed++;
        $display("[TB] FAIL bp_pre cycle %0d: got %h expected %h", c, obs, eg(2, c));
      end
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(r, '1, 5'b11011);
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL bp_stall cycle %0d: got %h expected 0", c, obs);
      end
    end
    applyStimulus(r, '1, '1);
    tests_run++;
    if (obs !== eg(2, 2)) begin
      tests_failed++;
      $display("[TB] FAIL bp_resume: got %h expected %h", obs, eg(2, 2));
    end
  endtask

  task automatic test_parallel();
    logic [N*M-1:0] r;
    logic [OW-1:0]  e;
    do_reset();
    r = '0;
    e = '0;
    for (int i = 0; i < N; i++) begin
      r = r | rq(i, (i + 1) % M);
      e = e | eg((i + 1) % M, i);
    end
    applyStimulus(r, '1, '1);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("[TB] FAIL parallel: got %h expected %h", obs, e);
    end
    tests_run++;
    if (o_output_sel !== {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}) begin
      tests_failed++;
      $display("[TB] FAIL parallel_sel: got %h expected %h", o_output_sel,
               {3'd3, 3'd2, 3'd1, 3'd0, 3'd4});
    end
  endtask

  task automatic test_idle();
    do_reset();
    applyStimulus('0, '1, '1);
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL idle_noreq: got %h expected 0", obs);
    end
    applyStimulus(rq(3, 1), '1, 5'b11101);
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL idle_noen: got %h expected 0", obs);
    end
    // Previous two cycles must not have moved ptr[1] off 0: input 3 wins
    // over input 4 only if the scan still starts below 3.
    applyStimulus(rq(3, 1) | rq(4, 1), '1, '1);
    tests_run++;
    if (obs !== eg(1, 3)) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: got %h expected %h", obs, eg(1, 3));
    end
  endtask

`ifdef ENOC_PKT_LOCK_EN
  task automatic test_lock();
    logic [N*M-1:0] both;
    int seq [4] = '{1, 1, 1, 3};
    logic [N-1:0] tl [4] = '{5'b11101, 5'b11101, 5'b11111, 5'b11101};
    both = rq(1, 4) | rq(3, 4);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(both, tl[c], '1);
      tests_run++;
      if (obs !== eg(4, seq[c])) begin
        tests_failed++;
        $display("[TB] FAIL lock cycle %0d: got %h expected %h", c, obs, eg(4, seq[c]));
      end
    end
  endtask

  task automatic test_lock_bubble();
    logic [N*M-1:0] both;
    both = rq(1, 4) | rq(3, 4);
    do_reset();
    applyStimulus(both, 5'b11101, '1);
    tests_run++;
    if (obs !== eg(4, 1)) begin
      tests_failed++;
      $display("[TB] FAIL bubble_f1: got %h expected %h", obs, eg(4, 1));
    end
    applyStimulus(rq(3, 4), 5'b11101, '1);
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL bubble_idle: got %h expected 0", obs);
    end
    applyStimulus(both, 5'b11101, '1);
    tests_run++;
    if (obs !== eg(4, 1)) begin
      tests_failed++;
      $display("[TB] FAIL bubble_f2: got %h expected %h", obs, eg(4, 1));
    end
    applyStimulus(both, 5'b11111, '1);
    tests_run++;
    if (obs !== eg(4, 1)) begin
      tests_failed++;
      $display("[TB] FAIL bubble_f3: got %h expected %h", obs, eg(4, 1));
    end
    applyStimulus(rq(3, 4), '1, '1);
    tests_run++;
    if (obs !== eg(4, 3)) begin
      tests_failed++;
      $display("[TB] FAIL bubble_after: got %h expected %h", obs, eg(4, 3));
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [N*M-1:0] both;
    both = rq(1, 4) | rq(3, 4);
    do_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(both, 5'b11101, '1);
      tests_run++;
      if (obs !== eg(4, 1)) begin
        tests_failed++;
        $display("[TB] FAIL midrst_flit cycle %0d: got %h expected %h", c, obs, eg(4, 1));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL midrst_during cycle %0d: got %h expected 0", c, obs);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs !== eg(4, 1)) begin
      tests_failed++;
      $display("[TB] FAIL midrst_first: got %h expected %h", obs, eg(4, 1));
    end
    applyStimulus(both, 5'b11101, '1);
    tests_run++;
    if (obs !== eg(4, 1)) begin
      tests_failed++;
      $display("[TB] FAIL midrst_relock: got %h expected %h", obs, eg(4, 1));
    end
  endtask
`else
  task automatic test_no_lock();
    logic [N*M-1:0] both;
    int seq [4] = '{1, 3, 1, 3};
    logic [N-1:0] tl [4] = '{5'b11101, 5'b11101, 5'b11111, 5'b11101};
    both = rq(1, 4) | rq(3, 4);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(both, tl[c], '1);
      tests_run++;
      if (obs !== eg(4, seq[c])) begin
        tests_failed++;
        $display("[TB] FAIL nolock cycle %0d: got %h expected %h", c, obs, eg(4, seq[c]));
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    i_output_req = '0;
    i_tail       = '1;
    i_en         = '1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_idle();
`ifdef ENOC_PKT_LOCK_EN
    test_lock();
    test_lock_bubble();
    test_reset_mid_packet();
`else
    test_no_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
